message_assembler: RTL and testbench

Receive-side counterpart of `message_slicer`. Accepts the debug-message word stream that `message_slicer` emits, one `MSG_WIDTH`-bit word per `in_nd` strobe. Reassembles each header word plus its payload words into one parallel message. Sits at the host/testbench end of the debug path, or in a hardware message collector that decodes module and error codes.

---
 rtl/message_assembler_pkg.sv | 36 +++
 rtl/message_assembler.sv | 126 ++++++++++++
 tb/tb_message_assembler.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/message_assembler_pkg.sv
// message_assembler_pkg
//   Shared debug-message definitions used by the message slicer and the
//   message assembler. The package holds the field widths, the
//   receive-FSM state encodings, the header field layout and the
//   header unpack helper.
package message_assembler_pkg;

    localparam int MSG_WIDTH_DEF        = 32;
    localparam int MSG_LENGTH_WIDTH     = 4;
    localparam int MSG_FORMATCODE_WIDTH = 4;
    localparam int MSG_MODULECODE_WIDTH = 7;
    localparam int MSG_ERRORCODE_WIDTH  = 16;

    // Header fields below the marker bit; this must equal MSG_WIDTH-1.
    localparam int MSG_HDR_BITS = MSG_LENGTH_WIDTH + MSG_FORMATCODE_WIDTH
                                + MSG_MODULECODE_WIDTH + MSG_ERRORCODE_WIDTH;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    // Field order from MSB to LSB, matching the packing side.
    typedef struct packed {
        logic [MSG_LENGTH_WIDTH-1:0]     length;
        logic [MSG_FORMATCODE_WIDTH-1:0] formatcode;
        logic [MSG_MODULECODE_WIDTH-1:0] modulecode;
        logic [MSG_ERRORCODE_WIDTH-1:0]  errorcode;
    } msg_header_t;

    function automatic msg_header_t message_header_unpack(
        input logic [MSG_HDR_BITS-1:0] fields
    );
        return msg_header_t'(fields);
    endfunction

endpackage

// File: rtl/message_assembler.sv
// message_assembler
//   Rebuilds parallel debug messages from the word stream that the
//   message slicer produces. A header word (MSB = 1) carries the length
//   and code fields. The payload words (MSB = 0) follow it. A completed
//   message is presented on out_* together with a one-cycle out_nd pulse.
//   Protocol violations set a sticky error flag.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   in_data        stream word
//   in_nd          in_data valid this cycle; every strobed word is consumed
//   out_length     payload word count of the last completed message
//   out_formatcode format code of the last completed message
//   out_modulecode module code of the last completed message
//   out_errorcode  error code of the last completed message
//   out_payload    payload, word i at [i*(MSG_WIDTH-1) +: MSG_WIDTH-1]
//   out_nd         one-cycle pulse when a message completes
//   error          sticky protocol-error flag, cleared only by reset
module message_assembler
    import message_assembler_pkg::*;
#(
    parameter int MSG_WIDTH = MSG_WIDTH_DEF,
    parameter int MAX_LEN   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [MSG_WIDTH-1:0]              in_data,
    input  logic                              in_nd,
    output logic [MSG_LENGTH_WIDTH-1:0]       out_length,
    output logic [MSG_FORMATCODE_WIDTH-1:0]   out_formatcode,
    output logic [MSG_MODULECODE_WIDTH-1:0]   out_modulecode,
    output logic [MSG_ERRORCODE_WIDTH-1:0]    out_errorcode,
    output logic [MAX_LEN*(MSG_WIDTH-1)-1:0]  out_payload,
    output logic                              out_nd,
    output logic                              error
);

    localparam int PW = MSG_WIDTH - 1;

    logic [1:0]                  state;
    logic [MSG_LENGTH_WIDTH-1:0] counter;
    msg_header_t                 pend;
    logic [MAX_LEN*PW-1:0]       buf_q;
    logic [MAX_LEN*PW-1:0]       next_buf;
    msg_header_t                 hdr;
    logic                        is_hdr;
    logic                        last_word;

    assign is_hdr    = in_data[MSG_WIDTH-1];
    assign hdr       = message_header_unpack(in_data[MSG_HDR_BITS-1:0]);
    assign last_word = (counter + MSG_LENGTH_WIDTH'(1)) == pend.length;

    // Working buffer with the incoming payload word merged at slot
    // `counter`. It is used both for the register update and for the
    // final copy to out_payload, so the last word needs no extra cycle.
    always_comb begin
        next_buf = buf_q;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (counter == MSG_LENGTH_WIDTH'(i))
                next_buf[i*PW +: PW] = in_data[PW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            counter        <= '0;
            pend           <= '0;
            buf_q          <= '0;
            out_length     <= '0;
            out_formatcode <= '0;
            out_modulecode <= '0;
            out_errorcode  <= '0;
            out_payload    <= '0;
            out_nd         <= 1'b0;
            error          <= 1'b0;
        end else begin
            out_nd <= 1'b0;
            if (in_nd) begin
                if (is_hdr) begin
                    // A header always resynchronises. Arriving mid-message
                    // it also aborts the partial message and flags an error.
                    if (state == ST_COLLECT)
                        error <= 1'b1;
                    if (hdr.length == '0) begin
                        out_length     <= hdr.length;
                        out_formatcode <= hdr.formatcode;
                        out_modulecode <= hdr.modulecode;
                        out_errorcode  <= hdr.errorcode;
                        out_payload    <= '0;
                        out_nd         <= 1'b1;
                        state          <= ST_IDLE;
                    end else if (hdr.length <= MSG_LENGTH_WIDTH'(MAX_LEN)) begin
                        pend    <= hdr;
                        buf_q   <= '0;
                        counter <= '0;
                        state   <= ST_COLLECT;
                    end else begin
                        error <= 1'b1;
                        state <= ST_DISCARD;
                    end
                end else begin
                    case (state)
                        ST_COLLECT: begin
                            buf_q   <= next_buf;
                            counter <= counter + MSG_LENGTH_WIDTH'(1);
                            if (last_word) begin
                                out_length     <= pend.length;
                                out_formatcode <= pend.formatcode;
                                out_modulecode <= pend.modulecode;
                                out_errorcode  <= pend.errorcode;
                                out_payload    <= next_buf;
                                out_nd         <= 1'b1;
                                state          <= ST_IDLE;
                            end
                        end
                        ST_DISCARD: ;
                        default:    error <= 1'b1;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_message_assembler.sv
module tb_message_assembler;

    localparam int W  = 32;
    localparam int ML = 4;
    localparam int PW = W - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_nd = 1'b0;
    logic [W-1:0]      in_data = '0;
    logic [3:0]        out_length;
    logic [3:0]        out_formatcode;
    logic [6:0]        out_modulecode;
    logic [15:0]       out_errorcode;
    logic [ML*PW-1:0]  out_payload;
    logic              out_nd;
    logic              error;

    always #5 clk = ~clk;

    message_assembler #(.MSG_WIDTH(W), .MAX_LEN(ML)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_nd          (in_nd),
        .out_length     (out_length),
        .out_formatcode (out_formatcode),
        .out_modulecode (out_modulecode),
        .out_errorcode  (out_errorcode),
        .out_payload    (out_payload),
        .out_nd         (out_nd),
        .error          (error)
    );

    int total  = 0;
    int bad    = 0;
    int npulse = 0;
    bit armed  = 0;

    // Reference model: collected payload words in a queue.
    bit               m_in_msg, m_disc;
    int               m_want;
    logic [26:0]      m_hdr;
    logic [PW-1:0]    q[$];

    bit               e_nd, e_error;
    logic [3:0]       e_len, e_fmt;
    logic [6:0]       e_mod;
    logic [15:0]      e_err;
    logic [ML*PW-1:0] e_pl;

    logic [3:0]       c_len;
    logic [6:0]       c_mod;
    logic [15:0]      c_err;
    logic [ML*PW-1:0] c_pl;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, a, e);
        end
    endtask

    task automatic emit(input int len, input logic [26:0] h);
        e_nd  = 1;
        e_len = 4'(len);
        e_fmt = h[26:23];
        e_mod = h[22:16];
        e_err = h[15:0];
        e_pl  = '0;
        foreach (q[i]) e_pl[i*PW +: PW] = q[i];
    endtask

    task automatic model(input bit r, input bit nd, input logic [W-1:0] w);
        int len;
        e_nd = 0;
        len  = int'(w[30:27]);
        if (r) begin
            e_error = 0; e_len = '0; e_fmt = '0; e_mod = '0; e_err = '0; e_pl = '0;
            m_in_msg = 0; m_disc = 0; q.delete();
        end else if (nd) begin
            if (w[W-1]) begin
                if (m_in_msg) e_error = 1;
                m_in_msg = 0; m_disc = 0; q.delete();
                if (len == 0) emit(0, w[26:0]);
                else if (len <= ML) begin
                    m_in_msg = 1; m_want = len; m_hdr = w[26:0];
                end else begin
                    e_error = 1; m_disc = 1;
                end
            end else if (m_in_msg) begin
                q.push_back(w[PW-1:0]);
                if (q.size() == m_want) begin
                    emit(m_want, m_hdr);
                    m_in_msg = 0;
                end
            end else if (!m_disc) begin
                e_error = 1;
            end
        end
    endtask

    // One cycle: check outputs settled from the previous edge, then drive.
    task automatic step(input bit r, input bit nd, input logic [W-1:0] w);
        @(negedge clk);
        if (armed) begin
            chk("out_nd", out_nd, e_nd);
            chk("error", error, e_error);
            chk("out_length", out_length, e_len);
            chk("out_formatcode", out_formatcode, e_fmt);
            chk("out_modulecode", out_modulecode, e_mod);
            chk("out_errorcode", out_errorcode, e_err);
            chk("out_payload", out_payload, e_pl);
            if (out_nd) begin
                npulse++;
                c_len = out_length; c_mod = out_modulecode;
                c_err = out_errorcode; c_pl = out_payload;
            end
        end
        rst = r; in_nd = nd; in_data = w;
        model(r, nd, w);
        if (r) armed = 1;
    endtask

    task automatic word(input logic [W-1:0] w);
        step(0, 1, w);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, '0);
    endtask

    initial begin
        int p0;
        step(1, 0, '0);
        step(1, 0, '0);

        // single-word payload
        p0 = npulse;
        word(32'h88000000); word(32'h12345678); idle(1);
        chk("t1 pulses", npulse - p0, 1);
        chk("t1 len", c_len, 1);
        chk("t1 payload", c_pl, 124'h12345678);
        chk("t1 codes", {c_mod, c_err}, 0);

        // two-word payload with gaps
        p0 = npulse;
        word(32'h90030005); idle(3); word(32'h00000001); idle(3);
        word(32'h7FFFFFFF); idle(2);
        chk("t2 pulses", npulse - p0, 1);
        chk("t2 len", c_len, 2);
        chk("t2 mod", c_mod, 3);
        chk("t2 err", c_err, 5);
        chk("t2 payload", c_pl, {31'h7FFFFFFF, 31'h00000001});

        // zero-length back-to-back
        p0 = npulse;
        word(32'h80000000); word(32'h80000000); word(32'h88000000);
        word(32'h00000042); idle(2);
        chk("t3 pulses", npulse - p0, 3);
        chk("t3 payload", c_pl, 124'h42);
        chk("t3 no error", error, 0);

        // payload in idle, then header mid-collect
        p0 = npulse;
        word(32'h00000055); idle(1);
        chk("t4 error", error, 1);
        chk("t4 no pulse", npulse - p0, 0);
        word(32'h90000000); word(32'h00000001);
        word(32'h88000000); word(32'h00000007); idle(1);
        chk("t4 pulses", npulse - p0, 1);
        chk("t4 len", c_len, 1);
        chk("t4 payload", c_pl, 124'h7);

        // oversize length, then a valid message
        p0 = npulse;
        word(32'hA8000000);
        for (int i = 0; i < 5; i++) word(32'h00000100 + i);
        word(32'h88000000); word(32'h00000009); idle(1);
        chk("t5 pulses", npulse - p0, 1);
        chk("t5 payload", c_pl, 124'h9);
        chk("t5 error", error, 1);

        // reset mid-message, reset wins over a strobed word
        word(32'h90000000); word(32'h00000003);
        step(1, 1, 32'h00000004); idle(1);
        chk("t6 rst error", error, 0);
        chk("t6 rst fields", {out_length, out_formatcode, out_modulecode, out_errorcode}, 0);
        chk("t6 rst payload", out_payload, 0);
        p0 = npulse;
        word(32'h88000000); word(32'h0000000A); idle(2);
        chk("t6 pulses", npulse - p0, 1);
        chk("t6 payload", c_pl, 124'hA);
        chk("t6 error", error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
